// File: rtl/mdu_if.sv
// Handshake/data bundle between the E stage and the multiply/divide unit.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             req;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] md_out;

  // Pipeline side: issues operations and reads results.
  modport master (
    output start, req, op, rs, rt,
    input  busy, done, hi, lo, md_out
  );

  // Unit side.
  modport slave (
    input  start, req, op, rs, rt,
    output busy, done, hi, lo, md_out
  );
endinterface

// File: rtl/mdu_param.sv
// Parametrised MIPS multiply/divide unit holding HI/LO, with multiply-accumulate modes.
// Arithmetic is evaluated on the commit edge from operands latched at issue; the
// counter models the configured per-class latency.
module mdu_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  // Operation codes shared with the decoder.
  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MADD  = 4'd4;
  localparam logic [3:0] MDU_MADDU = 4'd5;
  localparam logic [3:0] MDU_MSUB  = 4'd6;
  localparam logic [3:0] MDU_MSUBU = 4'd7;
  localparam logic [3:0] MDU_MFHI  = 4'd8;
  localparam logic [3:0] MDU_MFLO  = 4'd9;
  localparam logic [3:0] MDU_MTHI  = 4'd10;
  localparam logic [3:0] MDU_MTLO  = 4'd11;

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {StIdle, StRun} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               latch_en;
  logic               issue;

  logic               sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, res;
  logic [WIDTH-1:0]   q_s, r_s;
  logic               div_zero, div_ovf;

  assign issue = bus.start & ~bus.req & (state_q == StIdle);

  // Datapath result for the latched operation, applied on the commit edge.
  always_comb begin
    sgn      = (op_q == MDU_MULT) || (op_q == MDU_MADD) || (op_q == MDU_MSUB) ||
               (op_q == MDU_DIV);
    ext_a    = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b    = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of the extended product are correct for both signednesses.
    prod     = ext_a * ext_b;
    acc      = {hi_q, lo_q};
    div_zero = (b_q == '0);
    div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    q_s      = $signed(a_q) / $signed(b_q);
    r_s      = $signed(a_q) % $signed(b_q);
    res      = acc;
    case (op_q)
      MDU_MULT, MDU_MULTU: res = prod;
      MDU_MADD, MDU_MADDU: res = acc + prod;
      MDU_MSUB, MDU_MSUBU: res = acc - prod;
      MDU_DIV: begin
        if (div_ovf) res = {{WIDTH{1'b0}}, a_q};
        else         res = {r_s, q_s};
      end
      MDU_DIVU:            res = {a_q % b_q, a_q / b_q};
      default:             res = acc;
    endcase
  end

  // Next-state, HI/LO update and done pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
              state_d  = StRun;
              cnt_d    = CNT_W'(MUL_CYCLES - 1);
              latch_en = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
              state_d  = StRun;
              cnt_d    = CNT_W'(DIV_CYCLES - 1);
              latch_en = 1'b1;
            end
            MDU_MTHI: hi_d = bus.rs;
            MDU_MTLO: lo_d = bus.rs;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
          // Divide by zero leaves HI/LO untouched but still completes.
          if (!(((op_q == MDU_DIV) || (op_q == MDU_DIVU)) && div_zero)) begin
            {hi_d, lo_d} = res;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and architectural state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Operand/opcode capture on an accepted multi-cycle issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (latch_en) begin
      op_q <= bus.op;
      a_q  <= bus.rs;
      b_q  <= bus.rt;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.md_out = (bus.op == MDU_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// Directed-vector bench for mdu_param with hand-computed expected results.
module tb_mdu_param;

  localparam logic [3:0] MULT = 4'd0, MULTU = 4'd1, DIV = 4'd2, DIVU = 4'd3;
  localparam logic [3:0] MADD = 4'd4, MADDU = 4'd5, MSUB = 4'd6, MSUBU = 4'd7;
  localparam logic [3:0] MFHI = 4'd8, MFLO = 4'd9, MTHI = 4'd10, MTLO = 4'd11;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one start cycle at a falling edge; returns at the next falling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic req);
    bus.start = 1'b1;
    bus.req   = req;
    bus.op    = op;
    bus.rs    = rs;
    bus.rt    = rt;
    @(negedge clk);
    bus.start = 1'b0;
    bus.req   = 1'b0;
  endtask

  // Issues a multi-cycle op and checks latency, done pulse and committed HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int cycles, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    issue(op, rs, rt, 1'b0);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 64'(n), 64'(cycles));
    check({tag, " done"}, {63'd0, bus.done}, 64'd1);
    check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    @(negedge clk);
    check({tag, " done clears"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.req   = 1'b0;
    bus.op    = MFLO;
    bus.rs    = '0;
    bus.rt    = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult -3*4", MULT, 32'hFFFF_FFFD, 32'd4, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op("divu 7/2", DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Squashed issues have no effect.
    issue(MULT, 32'd3, 32'd3, 1'b1);
    check("squashed mult busy", {63'd0, bus.busy}, 64'd0);
    check("squashed mult hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(MTLO, 32'd5, 32'd0, 1'b1);
    check("squashed mtlo lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
    issue(4'hF, 32'd1, 32'd1, 1'b0);
    check("unknown op busy", {63'd0, bus.busy}, 64'd0);
    check("unknown op hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // Moves to HI/LO and reads back through md_out.
    issue(MTHI, 32'd0, 32'd0, 1'b0);
    check("mthi busy", {63'd0, bus.busy}, 64'd0);
    check("mthi done", {63'd0, bus.done}, 64'd0);
    issue(MTLO, 32'd10, 32'd0, 1'b0);
    check("mtlo hilo", {bus.hi, bus.lo}, 64'd10);
    bus.op = MFHI;
    #1 check("mfhi md_out", {32'd0, bus.md_out}, 64'd0);
    bus.op = MFLO;
    #1 check("mflo md_out", {32'd0, bus.md_out}, 64'd10);
    @(negedge clk);

    run_op("maddu 2*3", MADDU, 32'd2, 32'd3, 5, 32'd0, 32'd16);
    run_op("msub 1*20", MSUB, 32'd1, 32'd20, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    run_op("msubu 1*1", MSUBU, 32'd1, 32'd1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op("madd -1*2", MADD, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    // Divide by zero keeps HI/LO.
    issue(MTHI, 32'd9, 32'd0, 1'b0);
    issue(MTLO, 32'd9, 32'd0, 1'b0);
    run_op("div by 0", DIV, 32'd5, 32'd0, 10, 32'd9, 32'd9);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1);

    // start during RUN is ignored; req during RUN does not cancel.
    begin
      int n;
      issue(MULT, 32'd2, 32'd3, 1'b0);
      bus.start = 1'b1;
      bus.req   = 1'b1;
      bus.op    = MTLO;
      bus.rs    = 32'd77;
      @(negedge clk);
      bus.start = 1'b0;
      bus.req   = 1'b0;
      n = 1;
      while (bus.busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("run ignore busy cycles", 64'(n), 64'd5);
      check("run ignore hilo", {bus.hi, bus.lo}, 64'd6);
      @(negedge clk);
    end

    // Reset in the third RUN cycle aborts at once.
    issue(MULT, 32'd7, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    check("pre-abort busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort no done", {62'd0, bus.done, bus.busy}, 64'd0);
    end
    check("abort hilo held", {bus.hi, bus.lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
